// File: rtl/issue_queue_nxm.sv
// Collapsing issue queue: accepts up to DISP_W micro-ops per cycle, issues up
// to ISS_W ready micro-ops per cycle (oldest first), snoops WAKE_W writeback
// tags, and handles branch kill/clear and full flush.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_flush                 discard all entries
//   i_disp_valid/data       dispatch lanes; o_disp_ready = room for a full group
//   i_wdest/i_wdest_valid   wakeup destination tags
//   i_BrKill, i_brclr       {enKill, mask} kill and resolved-bit clear
//   o_issue_valid/data      issue ports, i_issue_ready backpressure
//   o_count                 occupied entries
module issue_queue_nxm #(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned DISP_W    = 4,
  parameter int unsigned ISS_W     = 2,
  parameter int unsigned WAKE_W    = 4,
  parameter int unsigned WIDTH_REG = 5,
  parameter int unsigned WIDTH_BRM = 3,
  parameter int unsigned PAYLOAD_W = 12,
  localparam int unsigned ENT_W    = PAYLOAD_W + WIDTH_BRM + 3*WIDTH_REG + 2,
  localparam int unsigned OUT_W    = PAYLOAD_W + WIDTH_BRM + 3*WIDTH_REG,
  localparam int unsigned CNT_W    = $clog2(SIZE + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flush,
  input  logic [DISP_W-1:0]           i_disp_valid,
  input  logic [DISP_W*ENT_W-1:0]     i_disp_data,
  output logic                        o_disp_ready,
  input  logic [WAKE_W*WIDTH_REG-1:0] i_wdest,
  input  logic [WAKE_W-1:0]           i_wdest_valid,
  input  logic [WIDTH_BRM:0]          i_BrKill,
  input  logic [WIDTH_BRM-1:0]        i_brclr,
  output logic [ISS_W-1:0]            o_issue_valid,
  output logic [ISS_W*OUT_W-1:0]      o_issue_data,
  input  logic [ISS_W-1:0]            i_issue_ready,
  output logic [CNT_W-1:0]            o_count
);

  // Field offsets inside a packed entry {payload, brmask, prd, prs2, rdy2, prs1, rdy1}
  localparam int unsigned RDY1_B = 0;
  localparam int unsigned PRS1_L = 1;
  localparam int unsigned RDY2_B = WIDTH_REG + 1;
  localparam int unsigned PRS2_L = WIDTH_REG + 2;
  localparam int unsigned PRD_L  = 2*WIDTH_REG + 2;
  localparam int unsigned BRM_L  = 3*WIDTH_REG + 2;
  localparam int unsigned PAY_L  = BRM_L + WIDTH_BRM;

  logic [ENT_W-1:0] ent_q [SIZE];
  logic [SIZE-1:0]  vld_q;
  logic [CNT_W-1:0] count_q;
  logic             disp_ready_q;

  logic                 kill_en;
  logic [WIDTH_BRM-1:0] kill_mask;
  logic [SIZE-1:0]      ready, killed, issued, surv;
  logic [DISP_W-1:0]    take;
  logic [ENT_W-1:0]     sel_ent [ISS_W];
  logic [SIZE-1:0]      sel_oh  [ISS_W];
  logic [ISS_W-1:0]     sel_hit;
  logic [ENT_W-1:0]     nxt_ent [SIZE];
  logic [SIZE-1:0]      nxt_vld;
  logic [CNT_W-1:0]     nxt_count;

  // True when any valid wakeup port carries the given tag
  function automatic logic wake_hit(input logic [WIDTH_REG-1:0]        tag,
                                    input logic [WAKE_W*WIDTH_REG-1:0] wdest,
                                    input logic [WAKE_W-1:0]           wvld);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_W; w++) begin
      if (wvld[w] && (wdest[w*WIDTH_REG +: WIDTH_REG] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Apply wakeup snoop and branch-bit clear to an entry
  function automatic logic [ENT_W-1:0] refresh(input logic [ENT_W-1:0]            e,
                                               input logic [WAKE_W*WIDTH_REG-1:0] wdest,
                                               input logic [WAKE_W-1:0]           wvld,
                                               input logic [WIDTH_BRM-1:0]        clr);
    logic [ENT_W-1:0] r;
    r = e;
    r[RDY1_B] = e[RDY1_B] | wake_hit(e[PRS1_L +: WIDTH_REG], wdest, wvld);
    r[RDY2_B] = e[RDY2_B] | wake_hit(e[PRS2_L +: WIDTH_REG], wdest, wvld);
    r[BRM_L +: WIDTH_BRM] = e[BRM_L +: WIDTH_BRM] & ~clr;
    return r;
  endfunction

  assign kill_en   = i_BrKill[WIDTH_BRM];
  assign kill_mask = i_BrKill[WIDTH_BRM-1:0];

  // Per-entry ready and kill status
  always_comb begin
    ready  = '0;
    killed = '0;
    for (int i = 0; i < SIZE; i++) begin
      ready[i]  = vld_q[i] & ent_q[i][RDY1_B] & ent_q[i][RDY2_B];
      killed[i] = vld_q[i] & kill_en & (|(ent_q[i][BRM_L +: WIDTH_BRM] & kill_mask));
    end
  end

  // Oldest-first selection: the entry whose ready-rank equals p goes to port p
  always_comb begin
    logic [CNT_W-1:0] rank;
    rank = '0;
    for (int p = 0; p < ISS_W; p++) begin
      sel_hit[p] = 1'b0;
      sel_ent[p] = '0;
      sel_oh[p]  = '0;
    end
    for (int i = 0; i < SIZE; i++) begin
      if (ready[i]) begin
        for (int p = 0; p < ISS_W; p++) begin
          if (rank == CNT_W'(p)) begin
            sel_hit[p]   = 1'b1;
            sel_ent[p]   = ent_q[i];
            sel_oh[p][i] = 1'b1;
          end
        end
        rank = rank + CNT_W'(1);
      end
    end
  end

  // Issue ports: same-cycle kill suppresses valid, clear is applied to the mask
  always_comb begin
    o_issue_valid = '0;
    o_issue_data  = '0;
    issued        = '0;
    for (int p = 0; p < ISS_W; p++) begin
      o_issue_valid[p] = sel_hit[p] &
                         ~(kill_en & (|(sel_ent[p][BRM_L +: WIDTH_BRM] & kill_mask)));
      o_issue_data[p*OUT_W +: OUT_W] = {sel_ent[p][PAY_L +: PAYLOAD_W],
                                        sel_ent[p][BRM_L +: WIDTH_BRM] & ~i_brclr,
                                        sel_ent[p][PRD_L +: WIDTH_REG],
                                        sel_ent[p][PRS2_L +: WIDTH_REG],
                                        sel_ent[p][PRS1_L +: WIDTH_REG]};
      if (o_issue_valid[p] && i_issue_ready[p]) issued = issued | sel_oh[p];
    end
  end

  // Survivors and accepted dispatch lanes
  always_comb begin
    surv = vld_q & ~issued & ~killed;
    take = '0;
    for (int k = 0; k < DISP_W; k++) begin
      take[k] = disp_ready_q & i_disp_valid[k] &
                ~(kill_en & (|(i_disp_data[k*ENT_W + BRM_L +: WIDTH_BRM] & kill_mask)));
    end
  end

  // Compaction: survivors in age order, then accepted lanes in lane order
  always_comb begin
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] spos [SIZE];
    logic [CNT_W-1:0] dpos [DISP_W];
    acc = '0;
    for (int i = 0; i < SIZE; i++) begin
      spos[i] = acc;
      acc     = acc + CNT_W'(surv[i]);
    end
    for (int k = 0; k < DISP_W; k++) begin
      dpos[k] = acc;
      acc     = acc + CNT_W'(take[k]);
    end
    nxt_count = acc;
    nxt_vld   = '0;
    for (int j = 0; j < SIZE; j++) begin
      nxt_ent[j] = '0;
      for (int i = 0; i < SIZE; i++) begin
        if (surv[i] && (spos[i] == CNT_W'(j))) begin
          nxt_vld[j] = 1'b1;
          nxt_ent[j] = refresh(ent_q[i], i_wdest, i_wdest_valid, i_brclr);
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if (take[k] && (dpos[k] == CNT_W'(j))) begin
          nxt_vld[j] = 1'b1;
          nxt_ent[j] = refresh(i_disp_data[k*ENT_W +: ENT_W], i_wdest, i_wdest_valid, i_brclr);
        end
      end
    end
  end

  // Control state; reset has priority over flush, both empty the queue
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      vld_q        <= '0;
      count_q      <= '0;
      disp_ready_q <= 1'b1;
    end else begin
      vld_q        <= nxt_vld;
      count_q      <= nxt_count;
      disp_ready_q <= (CNT_W'(SIZE) - nxt_count) >= CNT_W'(DISP_W);
    end
  end

  // Entry payload storage, qualified by vld_q
  always_ff @(posedge i_clk) begin
    for (int j = 0; j < SIZE; j++) ent_q[j] <= nxt_ent[j];
  end

  assign o_disp_ready = disp_ready_q;
  assign o_count      = count_q;

endmodule

// File: tb/tb_issue_queue_nxm.sv
// Directed bench for issue_queue_nxm (SIZE=8): reset, throughput, wakeup,
// full/backpressure, kill/clear, flush, same-cycle dispatch snoop.
module tb_issue_queue_nxm;
  localparam int unsigned SIZE  = 8;
  localparam int unsigned ENT_W = 32;
  localparam int unsigned OUT_W = 30;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [3:0]   disp_valid;
  logic [127:0] disp_data;
  logic         disp_ready;
  logic [19:0]  wdest;
  logic [3:0]   wdest_valid;
  logic [3:0]   br_kill;
  logic [2:0]   brclr;
  logic [1:0]   issue_valid;
  logic [59:0]  issue_data;
  logic [1:0]   issue_ready;
  logic [3:0]   count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  issue_queue_nxm #(.SIZE(SIZE)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_disp_valid(disp_valid), .i_disp_data(disp_data), .o_disp_ready(disp_ready),
    .i_wdest(wdest), .i_wdest_valid(wdest_valid),
    .i_BrKill(br_kill), .i_brclr(brclr),
    .o_issue_valid(issue_valid), .o_issue_data(issue_data),
    .i_issue_ready(issue_ready), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [11:0] pay, input logic [2:0] brm,
                                     input logic [4:0] prd, input logic [4:0] prs2,
                                     input logic r2, input logic [4:0] prs1, input logic r1);
    return {pay, brm, prd, prs2, r2, prs1, r1};
  endfunction

  function automatic logic [29:0] ox(input logic [11:0] pay, input logic [2:0] brm,
                                     input logic [4:0] prd, input logic [4:0] prs2,
                                     input logic [4:0] prs1);
    return {pay, brm, prd, prs2, prs1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    flush       = 1'b0;
    disp_valid  = '0;
    wdest_valid = '0;
    br_kill     = '0;
    brclr       = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wdest       = '0;
    issue_ready = 2'b11;
    disp_data   = '0;

    // Reset while dispatching
    disp_valid = 4'hF;
    for (int k = 0; k < 4; k++) disp_data[k*ENT_W +: ENT_W] = mk(12'h0FF, 3'b000, 5'd1, 5'd0, 1'b1, 5'd0, 1'b1);
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_ready", 64'(disp_ready), 64'd1);
    rst = 1'b0;
    idle();

    // Throughput: A..D all ready, both ports accept
    for (int k = 0; k < 4; k++)
      disp_data[k*ENT_W +: ENT_W] = mk(12'(12'h0A0 + k), 3'b000, 5'(k + 1), 5'(k + 2), 1'b1, 5'(k + 3), 1'b1);
    disp_valid = 4'hF;
    #1 chk("tp_empty_valid", 64'(issue_valid), 64'd0);
    tick(); disp_valid = '0;
    #1;
    chk("tp_count4", 64'(count), 64'd4);
    chk("tp_valid1", 64'(issue_valid), 64'd3);
    chk("tp_a", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h0A0, 3'b000, 5'd1, 5'd2, 5'd3)));
    chk("tp_b", 64'(issue_data[OUT_W +: OUT_W]), 64'(ox(12'h0A1, 3'b000, 5'd2, 5'd3, 5'd4)));
    tick(); #1;
    chk("tp_count2", 64'(count), 64'd2);
    chk("tp_c", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h0A2, 3'b000, 5'd3, 5'd4, 5'd5)));
    chk("tp_d", 64'(issue_data[OUT_W +: OUT_W]), 64'(ox(12'h0A3, 3'b000, 5'd4, 5'd5, 5'd6)));
    tick(); #1;
    chk("tp_count0", 64'(count), 64'd0);
    chk("tp_valid0", 64'(issue_valid), 64'd0);

    // Wakeup: prs1=5 not ready, woken on port 2
    disp_data[0 +: ENT_W] = mk(12'h0E0, 3'b000, 5'd6, 5'd0, 1'b1, 5'd5, 1'b0);
    disp_valid = 4'b0001;
    tick(); disp_valid = '0;
    #1;
    chk("wk_count", 64'(count), 64'd1);
    chk("wk_wait", 64'(issue_valid), 64'd0);
    wdest[10 +: 5] = 5'd5;
    wdest_valid    = 4'b0100;
    #1 chk("wk_same_cycle", 64'(issue_valid), 64'd0);
    tick(); wdest_valid = '0;
    #1;
    chk("wk_valid", 64'(issue_valid), 64'd1);
    chk("wk_data", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h0E0, 3'b000, 5'd6, 5'd0, 5'd5)));
    tick(); #1;
    chk("wk_drain", 64'(count), 64'd0);

    // Full / backpressure
    issue_ready = 2'b00;
    for (int k = 0; k < 4; k++)
      disp_data[k*ENT_W +: ENT_W] = mk(12'(12'h100 + k), 3'b000, 5'(k), 5'd0, 1'b1, 5'd0, 1'b1);
    disp_valid = 4'hF;
    tick(); #1;
    chk("full_count4", 64'(count), 64'd4);
    chk("full_ready4", 64'(disp_ready), 64'd1);
    for (int k = 0; k < 4; k++)
      disp_data[k*ENT_W +: ENT_W] = mk(12'(12'h104 + k), 3'b000, 5'(k + 4), 5'd0, 1'b1, 5'd0, 1'b1);
    tick();
    // Junk group while full must be ignored
    for (int k = 0; k < 4; k++) disp_data[k*ENT_W +: ENT_W] = mk(12'hFFF, 3'b000, 5'd31, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    chk("full_count8", 64'(count), 64'd8);
    chk("full_ready8", 64'(disp_ready), 64'd0);
    chk("full_valid", 64'(issue_valid), 64'd3);
    chk("full_f0", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h100, 3'b000, 5'd0, 5'd0, 5'd0)));
    chk("full_f1", 64'(issue_data[OUT_W +: OUT_W]), 64'(ox(12'h101, 3'b000, 5'd1, 5'd0, 5'd0)));
    tick(); disp_valid = '0;
    #1;
    chk("bp_count8", 64'(count), 64'd8);
    chk("bp_f0", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h100, 3'b000, 5'd0, 5'd0, 5'd0)));
    chk("bp_f1", 64'(issue_data[OUT_W +: OUT_W]), 64'(ox(12'h101, 3'b000, 5'd1, 5'd0, 5'd0)));
    issue_ready = 2'b11;
    tick(); #1;
    chk("iss_count6", 64'(count), 64'd6);
    chk("iss_ready6", 64'(disp_ready), 64'd0);
    chk("iss_f2", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h102, 3'b000, 5'd2, 5'd0, 5'd0)));
    chk("iss_f3", 64'(issue_data[OUT_W +: OUT_W]), 64'(ox(12'h103, 3'b000, 5'd3, 5'd0, 5'd0)));
    tick(); #1;
    chk("iss_count4", 64'(count), 64'd4);
    chk("iss_ready4", 64'(disp_ready), 64'd1);
    tick(); tick(); #1;
    chk("full_drain", 64'(count), 64'd0);

    // Kill/clear
    issue_ready = 2'b00;
    disp_data[0*ENT_W +: ENT_W] = mk(12'h200, 3'b001, 5'd1, 5'd0, 1'b1, 5'd7, 1'b0);
    disp_data[1*ENT_W +: ENT_W] = mk(12'h201, 3'b010, 5'd2, 5'd0, 1'b1, 5'd0, 1'b1);
    disp_data[2*ENT_W +: ENT_W] = mk(12'h202, 3'b011, 5'd3, 5'd0, 1'b1, 5'd9, 1'b0);
    disp_data[3*ENT_W +: ENT_W] = mk(12'h203, 3'b100, 5'd4, 5'd0, 1'b1, 5'd0, 1'b1);
    disp_valid = 4'hF;
    tick(); disp_valid = '0;
    #1;
    chk("kc_count4", 64'(count), 64'd4);
    chk("kc_valid_pre", 64'(issue_valid), 64'd3);
    br_kill = 4'b1010;
    brclr   = 3'b001;
    #1;
    chk("kc_suppress", 64'(issue_valid), 64'd2);
    chk("kc_port1", 64'(issue_data[OUT_W +: OUT_W]), 64'(ox(12'h203, 3'b100, 5'd4, 5'd0, 5'd0)));
    tick(); br_kill = '0; brclr = '0;
    #1;
    chk("kc_count2", 64'(count), 64'd2);
    chk("kc_valid_post", 64'(issue_valid), 64'd1);
    chk("kc_k3", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h203, 3'b100, 5'd4, 5'd0, 5'd0)));
    wdest[0 +: 5] = 5'd7;
    wdest_valid   = 4'b0001;
    tick(); wdest_valid = '0;
    #1;
    chk("kc_valid_both", 64'(issue_valid), 64'd3);
    chk("kc_k0_mask", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h200, 3'b000, 5'd1, 5'd0, 5'd7)));
    chk("kc_k3_order", 64'(issue_data[OUT_W +: OUT_W]), 64'(ox(12'h203, 3'b100, 5'd4, 5'd0, 5'd0)));
    issue_ready = 2'b11;
    tick(); #1;
    chk("kc_drain", 64'(count), 64'd0);

    // Flush vs dispatch
    issue_ready = 2'b00;
    disp_data[0*ENT_W +: ENT_W] = mk(12'h300, 3'b000, 5'd1, 5'd0, 1'b1, 5'd0, 1'b1);
    disp_data[1*ENT_W +: ENT_W] = mk(12'h301, 3'b000, 5'd2, 5'd0, 1'b1, 5'd3, 1'b0);
    disp_data[2*ENT_W +: ENT_W] = mk(12'h302, 3'b000, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0);
    disp_data[3*ENT_W +: ENT_W] = mk(12'h303, 3'b000, 5'd4, 5'd0, 1'b1, 5'd0, 1'b1);
    disp_valid = 4'b0111;
    tick(); #1;
    chk("fl_count3", 64'(count), 64'd3);
    flush      = 1'b1;
    disp_valid = 4'hF;
    #1 chk("fl_valid_comb", 64'(issue_valid), 64'd1);
    tick(); idle();
    #1;
    chk("fl_count0", 64'(count), 64'd0);
    chk("fl_valid0", 64'(issue_valid), 64'd0);
    chk("fl_ready", 64'(disp_ready), 64'd1);

    // Sparse lanes with same-cycle dispatch snoop and clear
    disp_data[0*ENT_W +: ENT_W] = mk(12'hBAD, 3'b000, 5'd9, 5'd0, 1'b1, 5'd0, 1'b1);
    disp_data[1*ENT_W +: ENT_W] = mk(12'h400, 3'b000, 5'd5, 5'd0, 1'b1, 5'd12, 1'b0);
    disp_data[2*ENT_W +: ENT_W] = mk(12'hBAE, 3'b000, 5'd9, 5'd0, 1'b1, 5'd0, 1'b1);
    disp_data[3*ENT_W +: ENT_W] = mk(12'h401, 3'b110, 5'd6, 5'd0, 1'b1, 5'd0, 1'b1);
    disp_valid     = 4'b1010;
    wdest[15 +: 5] = 5'd12;
    wdest_valid    = 4'b1000;
    brclr          = 3'b010;
    tick(); idle();
    #1;
    chk("sn_count2", 64'(count), 64'd2);
    chk("sn_valid", 64'(issue_valid), 64'd3);
    chk("sn_lane1", 64'(issue_data[0 +: OUT_W]), 64'(ox(12'h400, 3'b000, 5'd5, 5'd0, 5'd12)));
    chk("sn_lane3", 64'(issue_data[OUT_W +: OUT_W]), 64'(ox(12'h401, 3'b100, 5'd6, 5'd0, 5'd0)));
    issue_ready = 2'b11;
    tick(); #1;
    chk("sn_drain", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/issue_queue_nxm.md
Name: issue_queue_nxm

Overview:
- Parametrised collapsing issue queue: accepts up to DISP_W renamed micro-ops per cycle, issues up to ISS_W ready micro-ops per cycle, oldest first.
- Sits between rename/dispatch and the execution-unit register-read stage.
- Each entry snoops WAKE_W writeback destination ports for operand wakeup.
- Adds branch-mask kill/clear, full flush and per-port valid/ready issue backpressure.

Parameters:
- SIZE, 16, number of entries; must be >= DISP_W.
- DISP_W, 4, dispatch lanes.
- ISS_W, 2, issue ports.
- WAKE_W, 4, wakeup destination ports.
- WIDTH_REG, 5, physical register tag width.
- WIDTH_BRM, 3, branch mask width.
- PAYLOAD_W, 12, opaque payload (opcode, funct, ROB tag).
- ENT_W, PAYLOAD_W+WIDTH_BRM+3*WIDTH_REG+2, packed dispatch entry {payload, brmask, prd, prs2, rdy2, prs1, rdy1}.
- OUT_W, PAYLOAD_W+WIDTH_BRM+3*WIDTH_REG, packed issue entry {payload, brmask, prd, prs2, prs1}.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  discard all entries.
- i_disp_valid  in  DISP_W  per-lane dispatch valid.
- i_disp_data  in  DISP_W*ENT_W  lane k occupies bits [k*ENT_W +: ENT_W].
- o_disp_ready  out  1  queue can accept a full dispatch group.
- i_wdest  in  WAKE_W*WIDTH_REG  wakeup destination tags.
- i_wdest_valid  in  WAKE_W  per-port wakeup valid.
- i_BrKill  in  WIDTH_BRM+1  {enKill, BranchMask}.
- i_brclr  in  WIDTH_BRM  resolved-correct branch bits to clear in all masks.
- o_issue_valid  out  ISS_W  per-port issue valid.
- o_issue_data  out  ISS_W*OUT_W  port p occupies bits [p*OUT_W +: OUT_W].
- i_issue_ready  in  ISS_W  execution unit accepts port p.
- o_count  out  $clog2(SIZE+1)  occupied entries (registered).

Behaviour:
- State: SIZE entries in age order; slot 0 is oldest. Valid entries are always contiguous from slot 0.
- Reset:
  - All entries become invalid and o_count=0 at the clock edge with i_rst=1.
  - After reset, o_issue_valid=0 and o_disp_ready=1.
- Ready entry: valid & rdy1 & rdy2.
- Selection (combinational from registered state):
  - The first ISS_W ready entries in age order map to ports 0..ISS_W-1; port 0 gets the oldest.
  - Unused ports drive o_issue_valid=0.
- Same-cycle kill suppression: o_issue_valid[p] is 0 if i_BrKill[WIDTH_BRM]=1 and (entry brmask & i_BrKill mask) != 0.
- Issue output: o_issue_data brmask = stored brmask & ~i_brclr.
- Handshake: an entry leaves at the edge when o_issue_valid[p] & i_issue_ready[p]. Otherwise it stays, and selection is recomputed next cycle; the port is not held sticky.
- Wakeup:
  - Any valid i_wdest matching prs1/prs2 sets rdy1/rdy2 at the edge.
  - Wakeup-to-issue latency is 1 cycle.
  - Entries dispatched in the same cycle also snoop i_wdest; the dispatch-time rdy bits are OR'd with the snoop result.
- Branch kill: when enKill=1, every stored entry and every dispatching entry whose mask intersects BranchMask is dropped at the edge.
- Branch clear:
  - i_brclr bits are cleared in all surviving masks, including dispatching entries.
  - If kill and clear hit the same bit in the same cycle, kill wins.
- Next-state compaction:
  - Survivors (not issued, not killed) are compacted in age order.
  - Accepted dispatch lanes are then appended in lane order; lanes with i_disp_valid=0 are skipped.
- Dispatch acceptance:
  - o_disp_ready = (SIZE - o_count) >= DISP_W. This is conservative: it ignores same-cycle issue and kill.
  - The group is accepted only if o_disp_ready=1. If o_disp_ready=0, all lanes are ignored and upstream must hold.
- Flush: i_flush=1 empties the queue at the edge. Dispatch in that cycle is ignored, and o_issue_valid is unaffected that cycle (comb view). Reset has priority over flush.
- Count: o_count_next = survivors + accepted dispatches; it never exceeds SIZE.

Test Plan:
- Reset: hold i_rst=1 with dispatch active -> next cycle o_count=0, o_issue_valid=00, o_disp_ready=1.
- Throughput: dispatch 4 entries all rdy=1, i_issue_ready=11 -> cycle+1 ports issue entries A,B; cycle+2 C,D; o_count 4->2->0.
- Wakeup: dispatch entry prs1=5, rdy1=0; at t drive i_wdest port2=5 valid -> o_issue_valid[0]=1 at t+1, not at t.
- Full/backpressure (SIZE=8):
  - Two groups of 4 -> o_count=8, o_disp_ready=0.
  - i_issue_ready=00 keeps the same oldest two presented unchanged.
  - Issue 2 -> count 6, still not ready.
  - Issue 2 more -> count 4, o_disp_ready=1.
- Kill/clear: masks 001,010,011,100; i_BrKill=1_010 with i_brclr=001 -> count 4->2, survivors' masks 000,100, order kept; a matching entry presented on an issue port shows valid=0 that cycle.
- Flush vs dispatch: queue holds 3, i_flush=1 with 4-lane dispatch -> next cycle o_count=0; dispatch dropped.
